// File: rtl/sum_pkg.sv
// Shared types and default sizing for the sum accumulator.
// Holds the FSM state encoding and the default operand/counter widths.
package sum_pkg;

   localparam int DEF_WIDTH = 9;
   localparam int DEF_CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/carry_lookahead_adder.sv
// WIDTH-bit adder: 4-bit lookahead blocks chained by block carry,
// with any leftover high bits finished as a short ripple tail.
module carry_lookahead_adder #(
   parameter int WIDTH = 9
) (
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             carry_in,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out
);

   localparam int NBLK = WIDTH / 4;

   logic [WIDTH-1:0] g;
   logic [WIDTH-1:0] p;

   assign g = x & y;
   assign p = x ^ y;

   always_comb begin
      logic cy;
      logic c1;
      logic c2;
      logic c3;
      // NOTE: every variable gets a default first so no path through this block infers a latch.
      sum = '0;
      cy  = carry_in;
      c1  = 1'b0;
      c2  = 1'b0;
      c3  = 1'b0;
      for (int b = 0; b < NBLK; b++) begin
         c1 = g[4*b] | (p[4*b] & cy);
         c2 = g[4*b+1] | (p[4*b+1] & g[4*b]) | ((&p[4*b +: 2]) & cy);
         c3 = g[4*b+2] | (p[4*b+2] & g[4*b+1]) | ((&p[4*b+1 +: 2]) & g[4*b])
            | ((&p[4*b +: 3]) & cy);
         sum[4*b +: 4] = p[4*b +: 4] ^ {c3, c2, c1, cy};
         // Block carry-out from group generate/propagate, not from c3.
         cy = g[4*b+3] | (p[4*b+3] & g[4*b+2]) | ((&p[4*b+2 +: 2]) & g[4*b+1])
            | ((&p[4*b+1 +: 3]) & g[4*b]) | ((&p[4*b +: 4]) & cy);
      end
      for (int i = NBLK * 4; i < WIDTH; i++) begin
         sum[i] = p[i] ^ cy;
         cy     = g[i] | (p[i] & cy);
      end
      carry_out = cy;
   end

endmodule

// File: rtl/sum_accumulator.sv
// Streaming group accumulator: sums beats until in_last, then holds the result until handoff.
// Define SUM_ACC_SATURATE_EN to clamp the sum at all ones on carry instead of wrapping.
module sum_accumulator
   import sum_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_ovf,
   output logic [CNT_W-1:0] out_count
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic             ovf_q, ovf_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             armed_q, armed_d;

   logic [WIDTH-1:0] add_sum;
   logic             add_carry;
   logic             beat;
   logic             handoff;

   carry_lookahead_adder #(
      .WIDTH(WIDTH)
   ) u_adder (
      .x        (acc_q),
      .y        (in_data),
      .carry_in (1'b0),
      .sum      (add_sum),
      .carry_out(add_carry)
   );

   // armed_q keeps in_ready low while in reset and for the cycle of release.
   assign in_ready  = armed_q && (state_q != DONE);
   assign out_valid = (state_q == DONE);
   assign beat      = in_valid && in_ready;
   assign handoff   = out_valid && out_ready;

   assign out_sum   = acc_q;
   assign out_ovf   = ovf_q;
   assign out_count = count_q;

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      ovf_d   = ovf_q;
      count_d = count_q;
      armed_d = 1'b1;
      if (clear) begin
         state_d = IDLE;
         acc_d   = '0;
         ovf_d   = 1'b0;
         count_d = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (beat) begin
                  acc_d   = in_data;
                  ovf_d   = 1'b0;
                  count_d = CNT_W'(1);
                  state_d = in_last ? DONE : ACC;
               end
            end
            ACC: begin
               if (beat) begin
`ifdef SUM_ACC_SATURATE_EN
                  acc_d = add_carry ? '1 : add_sum;
`else
                  acc_d = add_sum;
`endif
                  ovf_d   = ovf_q | add_carry;
                  count_d = (count_q == CNT_MAX) ? count_q : count_q + CNT_W'(1);
                  if (in_last) begin
                     state_d = DONE;
                  end
               end
            end
            DONE: begin
               if (handoff) begin
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of block order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         acc_q   <= '0;
         ovf_q   <= 1'b0;
         count_q <= '0;
         armed_q <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         ovf_q   <= ovf_d;
         count_q <= count_d;
         armed_q <= armed_d;
      end
   end

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed self-checking bench for sum_accumulator (WIDTH=9, CNT_W=4).
// Expected values are hand-computed; SUM_ACC_SATURATE_EN selects the clamped expectations.
module tb_sum_accumulator;

   logic       clk;
   logic       rst_n;
   logic       clear;
   logic       in_valid;
   logic       in_ready;
   logic [8:0] in_data;
   logic       in_last;
   logic       out_valid;
   logic       out_ready;
   logic [8:0] out_sum;
   logic       out_ovf;
   logic [3:0] out_count;

   int n_checks = 0;
   int n_errors = 0;

   sum_accumulator #(
      .WIDTH(9),
      .CNT_W(4)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (clear),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .in_last  (in_last),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_sum  (out_sum),
      .out_ovf  (out_ovf),
      .out_count(out_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Presents one beat across the next rising edge; called and returns at edge+1.
   task automatic send(input logic [8:0] data, input logic last);
      in_valid = 1'b1;
      in_data  = data;
      in_last  = last;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = '0;
      in_last  = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_result(input string tag, input logic [8:0] sum, input logic ovf,
                               input logic [3:0] cnt);
      check({tag, "_valid"}, 32'(out_valid), 32'h1);
      check({tag, "_sum"}, 32'(out_sum), 32'(sum));
      check({tag, "_ovf"}, 32'(out_ovf), 32'(ovf));
      check({tag, "_count"}, 32'(out_count), 32'(cnt));
      check({tag, "_in_ready"}, 32'(in_ready), 32'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n     = 1'b0;
      clear     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      out_ready = 1'b0;

      // Reset state
      #2;
      check("rst_in_ready", 32'(in_ready), 32'h0);
      check("rst_out_valid", 32'(out_valid), 32'h0);
      check("rst_sum", 32'(out_sum), 32'h0);
      check("rst_ovf", 32'(out_ovf), 32'h0);
      check("rst_count", 32'(out_count), 32'h0);
      tick();
      tick();
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("release_in_ready_before_edge", 32'(in_ready), 32'h0);
      tick();
      check("release_in_ready_after_edge", 32'(in_ready), 32'h1);

      // Basic two-beat group, single-cycle result
      out_ready = 1'b1;
      send(9'h003, 1'b0);
      check("basic_mid_valid", 32'(out_valid), 32'h0);
      check("basic_mid_sum", 32'(out_sum), 32'h003);
      check("basic_mid_count", 32'(out_count), 32'h1);
      send(9'h005, 1'b1);
      check_result("basic", 9'h008, 1'b0, 4'd2);
      tick();
      check("basic_pulse_valid", 32'(out_valid), 32'h0);
      check("basic_pulse_in_ready", 32'(in_ready), 32'h1);

      // Carry out of the top bit
      send(9'h1C0, 1'b0);
      send(9'h0C0, 1'b1);
`ifdef SUM_ACC_SATURATE_EN
      check_result("carry", 9'h1FF, 1'b1, 4'd2);
`else
      check_result("carry", 9'h080, 1'b1, 4'd2);
`endif
      tick();

      // Overflow flag stays set after a later carry-free addition
      send(9'h1FF, 1'b0);
      send(9'h001, 1'b0);
      check("sticky_mid_ovf", 32'(out_ovf), 32'h1);
      send(9'h005, 1'b1);
`ifdef SUM_ACC_SATURATE_EN
      check_result("sticky", 9'h1FF, 1'b1, 4'd3);
`else
      check_result("sticky", 9'h005, 1'b1, 4'd3);
`endif
      tick();

      // Backpressure: result held, offered beats refused
      out_ready = 1'b0;
      send(9'h0AA, 1'b1);
      in_valid = 1'b1;
      in_data  = 9'h055;
      for (int i = 0; i < 5; i++) begin
         check_result($sformatf("hold%0d", i), 9'h0AA, 1'b0, 4'd1);
         tick();
      end
      in_valid  = 1'b0;
      in_data   = '0;
      check_result("hold5", 9'h0AA, 1'b0, 4'd1);
      out_ready = 1'b1;
      tick();
      check("hold_after_valid", 32'(out_valid), 32'h0);
      check("hold_after_in_ready", 32'(in_ready), 32'h1);

      // Count saturation over 20 beats
      for (int i = 0; i < 20; i++) begin
         send(9'h001, (i == 19));
         if (i == 15) begin
            check("sat16_count", 32'(out_count), 32'hF);
            check("sat16_sum", 32'(out_sum), 32'h010);
         end
      end
      check_result("sat", 9'h014, 1'b0, 4'hF);
      tick();

      // Clear with a beat present discards both group and beat
      send(9'h010, 1'b0);
      send(9'h020, 1'b0);
      check("pre_clear_sum", 32'(out_sum), 32'h030);
      clear    = 1'b1;
      in_valid = 1'b1;
      in_data  = 9'h040;
      in_last  = 1'b1;
      tick();
      clear    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      in_last  = 1'b0;
      check("clear_valid", 32'(out_valid), 32'h0);
      check("clear_in_ready", 32'(in_ready), 32'h1);
      check("clear_sum", 32'(out_sum), 32'h0);
      check("clear_count", 32'(out_count), 32'h0);
      check("clear_ovf", 32'(out_ovf), 32'h0);
      send(9'h007, 1'b1);
      check_result("post_clear", 9'h007, 1'b0, 4'd1);
      tick();

      // Asynchronous reset mid-group
      send(9'h100, 1'b0);
      send(9'h0FF, 1'b0);
      check("pre_rst_sum", 32'(out_sum), 32'h1FF);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_sum", 32'(out_sum), 32'h0);
      check("arst_count", 32'(out_count), 32'h0);
      check("arst_in_ready", 32'(in_ready), 32'h0);
      check("arst_out_valid", 32'(out_valid), 32'h0);
      @(posedge clk);
      #2;
      check("arst_held_in_ready", 32'(in_ready), 32'h0);
      rst_n = 1'b1;
      #1;
      check("arst_release_in_ready", 32'(in_ready), 32'h0);
      tick();
      check("arst_edge_in_ready", 32'(in_ready), 32'h1);
      send(9'h004, 1'b1);
      check_result("post_rst", 9'h004, 1'b0, 4'd1);
      tick();
      check("final_valid", 32'(out_valid), 32'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
